nios_fprint_debug_access_arbiter: RTL and testbench
===================================================

Name: nios_fprint_debug_access_arbiter

Overview:
- Shares one debug-module OCI memory port among NUM_REQ requesters (per-core monitor and fingerprint-checker agents) using round-robin arbitration.
- Accepts one command at a time, issues an Avalon-style read or write to the debug-module slave, and returns the completion to the requester that owns it.
- Sits on the system clock domain, between the requesters and the debug module's sysclk-side register/memory slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 9, OCI memory word-address width.
- TIMEOUT_CYCLES, 1024, stall limit in ISSUE or WAIT_RD before a forced error completion (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*32  packed write data.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot completion strobe.
- rsp_rdata  out  32  read data, shared by all requesters.
- rsp_error  out  1  completion error flag, qualified by rsp_valid.
- m_address  out  ADDR_W  downstream address.
- m_read  out  1  downstream read.
- m_write  out  1  downstream write.
- m_writedata  out  32  downstream write data.
- m_waitrequest  in  1  downstream stall.
- m_readdata  in  32  downstream read data.
- m_readdatavalid  in  1  downstream read data valid.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or most recent owner.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-transaction: immediate return to IDLE; m_read/m_write drop asynchronously; the transaction in flight is abandoned with no rsp_valid.
- State machine: IDLE -> ISSUE -> (WAIT_RD) -> RESP -> IDLE.
- IDLE:
  - Winner is the first i with req_valid[i]=1, scanning last_grant+1 upward and wrapping modulo NUM_REQ.
  - req_ready[winner] is asserted combinationally in the same cycle.
  - The command is latched into m_address, m_writedata and the write flag; grant_id is registered; next state is ISSUE.
  - If no req_valid is high, the arbiter stays in IDLE.
- ISSUE:
  - m_read or m_write is held high and all m_* outputs stay stable while m_waitrequest=1.
  - When m_waitrequest=0: a write goes to RESP; a read goes to WAIT_RD.
  - Both strobes deassert on leaving ISSUE.
- WAIT_RD:
  - On m_readdatavalid=1, m_readdata is captured into rsp_rdata and the next state is RESP.
  - m_readdatavalid outside WAIT_RD is ignored. The downstream read latency is at least 1 cycle.
- RESP:
  - rsp_valid[grant_id]=1 for exactly one cycle; last_grant <= grant_id; next state IDLE.
  - rsp_rdata holds its value until the next read capture. It is not cleared after writes.
- Latency with zero waitstates, accept at cycle T:
  - Downstream strobe at T+1.
  - Write: rsp_valid at T+2; next accept possible at T+3.
  - Read with readdatavalid at T+k (k >= 2): rsp_valid at T+k+1.
- Requester contract:
  - Keep req_valid and the request fields stable until req_ready.
  - Do not issue a new request before rsp_valid.
  - Dropping req_valid early forfeits arbitration with no side effect.
- Simultaneous requests: exactly one grant per IDLE cycle. Under permanent contention each requester is served once per NUM_REQ transactions.
- rsp_error is 0 whenever the optional feature is compiled out.

Optional Feature:
- Macro: DBG_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and to WAIT_RD and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1 while the state is unfinished, m_read/m_write drop and the next state is RESP with rsp_error=1 and rsp_rdata=32'h0.
  - A normal completion in the same cycle as expiry wins, with rsp_error=0.
- Undefined: no counter; the arbiter waits indefinitely; rsp_error is tied to 0.

Test Plan:
- Single write: req0 write, addr 0x1A0, data 0xCAFEF00D, waitrequest low -> req_ready[0] at T, m_write=1 with those values at T+1, rsp_valid[0]=1 at T+2, rsp_error=0.
- Read with stall: req2 read addr 0x005, waitrequest high 3 cycles, readdatavalid 2 cycles later with 0x12345678 -> m_read held 4 cycles with a stable address, rsp_rdata=0x12345678 and rsp_valid[2] one cycle after readdatavalid.
- Fairness: all 4 req_valid held high for 8 transactions after reset -> grant order 0,1,2,3,0,1,2,3; no requester granted twice in a row.
- Reset during WAIT_RD: assert reset -> busy=0, m_read=0 immediately, no rsp_valid; after release, req1 is granted before req2.
- Timeout (DBG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): waitrequest stuck high -> m_read drops after 16 cycles, then rsp_valid with rsp_error=1 and rsp_rdata=0; without the macro the arbiter is still busy after 100 cycles.
- Readdatavalid while in IDLE or ISSUE -> rsp_rdata unchanged, no rsp_valid.

Source files
------------

// File: rtl/nios_fprint_debug_access_arbiter.sv
// nios_fprint_debug_access_arbiter: round-robin arbiter sharing one OCI memory port among NUM_REQ requesters.
// Define DBG_ARB_TIMEOUT_EN to force an error completion after TIMEOUT_CYCLES of downstream stall.
module nios_fprint_debug_access_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 9,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*32-1:0]      req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         rsp_valid,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_error,
   output logic [ADDR_W-1:0]          m_address,
   output logic                       m_read,
   output logic                       m_write,
   output logic [31:0]                m_writedata,
   input  logic                       m_waitrequest,
   input  logic [31:0]                m_readdata,
   input  logic                       m_readdatavalid,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);
   localparam int GW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;
   state_t state, next;
   logic [GW-1:0] last_grant, winner;
   logic found, wr_flag, done, timeout;

   function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
      int j;
      j = (int'(base) + off) % NUM_REQ;
      return GW'(j);
   endfunction

   assign done = (state == ISSUE && !m_waitrequest) || (state == WAIT_RD && m_readdatavalid);
   assign m_read = state == ISSUE && !wr_flag;
   assign m_write = state == ISSUE && wr_flag;
   assign busy = state != IDLE;

`ifdef DBG_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] cnt;
   logic err;
   // a completion arriving on the expiry cycle takes precedence over the timeout
   assign timeout = (state == ISSUE || state == WAIT_RD) && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
   assign rsp_error = state == RESP && err;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= (next != state) ? '0 : cnt + 1'b1;
         err <= timeout || (err && state != RESP);
      end
`else
   assign timeout = 1'b0;
   assign rsp_error = 1'b0;
`endif

   // scan from the requester after the last owner, wrapping around
   always_comb begin
      found = 1'b0;
      winner = '0;
      for (int i = 1; i <= NUM_REQ; i++)
         if (!found && req_valid[rr_idx(last_grant, i)]) begin
            found = 1'b1;
            winner = rr_idx(last_grant, i);
         end
   end

   always_comb begin
      next = state;
      req_ready = '0;
      rsp_valid = '0;
      case (state)
         IDLE:    next = found ? ISSUE : IDLE;
         ISSUE:   next = done ? (wr_flag ? RESP : WAIT_RD) : (timeout ? RESP : ISSUE);
         WAIT_RD: next = (done || timeout) ? RESP : WAIT_RD;
         default: next = IDLE;
      endcase
      if (state == IDLE && found) req_ready[winner] = 1'b1;
      if (state == RESP) rsp_valid[grant_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         last_grant <= GW'(NUM_REQ - 1);
         grant_id <= '0;
         wr_flag <= 1'b0;
         m_address <= '0;
         m_writedata <= '0;
         rsp_rdata <= '0;
      end else begin
         state <= next;
         if (state == IDLE && found) begin
            grant_id <= winner;
            wr_flag <= req_write[winner];
            m_address <= req_addr[winner*ADDR_W +: ADDR_W];
            m_writedata <= req_wdata[winner*32 +: 32];
         end
         if (state == WAIT_RD && m_readdatavalid) rsp_rdata <= m_readdata;
         else if (timeout) rsp_rdata <= '0;
         if (state == RESP) last_grant <= grant_id;
      end
endmodule

// File: tb/tb_nios_fprint_debug_access_arbiter.sv
// tb_nios_fprint_debug_access_arbiter: directed vectors, corner sequences and randomized traffic against a reference model.
module tb_nios_fprint_debug_access_arbiter;
   localparam int N = 4, AW = 9;
   logic clk = 1'b0, reset;
   logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*32-1:0] req_wdata;
   logic [31:0] rsp_rdata, m_writedata, m_readdata, last_rd;
   logic rsp_error, m_read, m_write, m_waitrequest, m_readdatavalid, busy;
   logic [AW-1:0] m_address;
   logic [1:0] grant_id;
   int checks = 0, passed = 0;
   int prev, grants, n, seen;

   typedef struct {int id; bit wr; logic [8:0] addr; logic [31:0] data; int nwait; int lat;} vec_t;
   vec_t vecs[6];

   int st[N];
   bit qw[N];
   logic [8:0] qa[N];
   logic [31:0] qd[N];
   logic [31:0] smem[512], ref_mem[512];
   int owner, last_w, rd_cnt;
   bit outst, rsp_due;
   logic [31:0] rd_buf;
   logic [N-1:0] exp_ready;

   always #5 clk = ~clk;

   nios_fprint_debug_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .busy(busy), .grant_id(grant_id));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      last_rd = '0;
   endtask

   task automatic run_txn(input vec_t v);
      req_valid = '0;
      req_valid[v.id] = 1;
      req_write[v.id] = v.wr;
      req_addr[v.id*AW +: AW] = v.addr;
      req_wdata[v.id*32 +: 32] = v.data;
      @(negedge clk);
      check("ready", req_ready, 32'(1 << v.id));
      cyc();
      req_valid = '0;
      for (int w = 0; w <= v.nwait; w++) begin
         m_waitrequest = w < v.nwait;
         m_readdatavalid = 1;
         m_readdata = 32'hFFFF0000;
         @(negedge clk);
         check("strobe", {m_write, m_read}, v.wr ? 2 : 1);
         check("m_address", m_address, v.addr);
         check("grant_id", grant_id, v.id);
         if (v.wr) check("m_writedata", m_writedata, v.data);
         cyc();
      end
      m_readdatavalid = 0;
      m_waitrequest = 0;
      if (!v.wr) begin
         for (int k = 1; k < v.lat; k++) begin
            @(negedge clk);
            check("no_early_rsp", rsp_valid, 0);
            check("strobe_off", {m_write, m_read}, 0);
            cyc();
         end
         m_readdatavalid = 1;
         m_readdata = v.data;
         cyc();
         m_readdatavalid = 0;
         m_readdata = '0;
         last_rd = v.data;
      end
      @(negedge clk);
      check("rsp_valid", rsp_valid, 32'(1 << v.id));
      check("rsp_error", rsp_error, 0);
      check("rsp_rdata", rsp_rdata, last_rd);
      cyc();
      @(negedge clk);
      check("idle_after", {busy, rsp_valid}, 0);
      cyc();
   endtask

   initial begin
      vecs[0] = '{0, 1'b1, 9'h1A0, 32'hCAFEF00D, 0, 0};
      vecs[1] = '{2, 1'b0, 9'h005, 32'h12345678, 3, 2};
      vecs[2] = '{1, 1'b1, 9'h0FF, 32'hA5A5A5A5, 1, 0};
      vecs[3] = '{3, 1'b0, 9'h1FF, 32'hDEADBEEF, 0, 1};
      vecs[4] = '{1, 1'b1, 9'h000, 32'h00000000, 0, 0};
      vecs[5] = '{0, 1'b0, 9'h010, 32'h0BADCAFE, 2, 3};

      do_reset();
      @(negedge clk);
      check("reset_ctrl", {req_ready, rsp_valid, busy, m_read, m_write, rsp_error, grant_id}, 0);
      check("reset_data", {rsp_rdata[22:0], m_address}, 0);
      check("reset_wdata", m_writedata, 0);
      cyc();

      for (int i = 0; i < 6; i++) run_txn(vecs[i]);

      m_readdatavalid = 1;
      m_readdata = 32'h13572468;
      repeat (2) begin
         @(negedge clk);
         check("idle_rdv_rdata", rsp_rdata, last_rd);
         check("idle_rdv_rsp", {busy, rsp_valid}, 0);
         cyc();
      end
      m_readdatavalid = 0;

      do_reset();
      req_valid = '1; req_write = '1;
      prev = N - 1; grants = 0;
      for (int c = 0; c < 100 && grants < 8; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            check("fair_grant", req_ready, 32'(1 << ((prev + 1) % N)));
            prev = (prev + 1) % N;
            grants++;
         end
         cyc();
      end
      check("fair_count", grants, 8);
      req_valid = '0;
      repeat (3) cyc();

      do_reset();
      req_valid = 4'b0010;
      req_addr[AW +: AW] = 9'h033;
      @(negedge clk);
      check("rst_ready", req_ready, 2);
      cyc();
      req_valid = '0;
      cyc();
      @(negedge clk);
      check("rst_pre_busy", busy, 1);
      #1 reset = 1;
      #1 check("rst_async", {busy, m_read, m_write, rsp_valid}, 0);
      @(posedge clk);
      #1 reset = 0;
      req_valid = 4'b0110; req_write = '1;
      @(negedge clk);
      check("rst_rr_order", req_ready, 2);
      cyc();
      req_valid = 4'b0100;
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
      cyc();
      @(negedge clk);
      check("rst_rsp", rsp_valid, 2);
      cyc();
      @(negedge clk);
      check("rst_next_grant", req_ready, 4);
      cyc();
      req_valid = '0;
      repeat (3) cyc();

      do_reset();
      req_valid = 4'b0001;
      m_waitrequest = 1;
      @(negedge clk);
      check("stuck_ready", req_ready, 1);
      cyc();
      req_valid = '0;
`ifdef DBG_ARB_TIMEOUT_EN
      n = 0; seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_read) n++;
         if (rsp_valid != 0) begin
            seen++;
            check("to_rsp", rsp_valid, 1);
            check("to_err", rsp_error, 1);
            check("to_rdata", rsp_rdata, 0);
         end
         cyc();
      end
      check("to_strobe_cycles", n, 16);
      check("to_seen", seen, 1);
`else
      repeat (100) cyc();
      @(negedge clk);
      check("stuck_busy", {busy, m_read}, 2'b11);
      check("stuck_rsp", rsp_valid, 0);
      cyc();
`endif
      m_waitrequest = 0;

      do_reset();
      for (int i = 0; i < 512; i++) begin
         smem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < N; i++) st[i] = 0;
      last_w = N - 1; outst = 0; rsp_due = 0; rd_cnt = 0; owner = 0;
      for (int c = 0; c < 600; c++) begin
         m_readdatavalid = 0;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               m_readdatavalid = 1;
               m_readdata = rd_buf;
            end
         end
         m_waitrequest = $urandom_range(0, 2) == 0;
         for (int i = 0; i < N; i++) begin
            if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
               st[i] = 1;
               qw[i] = 1'($urandom_range(0, 1));
               qa[i] = 9'($urandom_range(0, 7));
               qd[i] = $urandom;
               req_write[i] = qw[i];
               req_addr[i*AW +: AW] = qa[i];
               req_wdata[i*32 +: 32] = qd[i];
            end
            req_valid[i] = st[i] == 1;
         end
         @(negedge clk);
         exp_ready = '0;
         if (!outst)
            for (int k = 1; k <= N; k++)
               if (exp_ready == 0 && st[(last_w + k) % N] == 1) exp_ready[(last_w + k) % N] = 1'b1;
         check("rnd_ready", req_ready, exp_ready);
         for (int i = 0; i < N; i++)
            if (exp_ready[i]) begin
               outst = 1; owner = i; last_w = i; st[i] = 2;
            end
         check("rnd_rsp", rsp_valid, rsp_due ? 32'(1 << owner) : 0);
         if (rsp_due) begin
            check("rnd_err", rsp_error, 0);
            if (!qw[owner]) check("rnd_rdata", rsp_rdata, ref_mem[qa[owner]]);
            else ref_mem[qa[owner]] = qd[owner];
            st[owner] = 0; outst = 0; rsp_due = 0;
         end
         if ((m_read || m_write) && !m_waitrequest) begin
            check("rnd_addr", m_address, qa[owner]);
            check("rnd_dir", m_write, qw[owner]);
            if (m_write) begin
               check("rnd_wdata", m_writedata, qd[owner]);
               smem[m_address] = m_writedata;
               rsp_due = 1;
            end else begin
               rd_cnt = $urandom_range(1, 3);
               rd_buf = smem[m_address];
            end
         end
         if (m_readdatavalid) rsp_due = 1;
         cyc();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
